// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder for the single-cycle core.
// Word-addressed RAM (async read, sync write) plus an MMIO window holding a
// store-to-stream TX FIFO and a free-running cycle counter.
// Build option: define DMEM_RESP_CYCLE_CNT_EN to implement the CYCLE counter;
// when undefined, CYCLE reads return 0 and writes are ignored.
module dmem_resp #(
  parameter int unsigned RAM_AW  = 10,
  parameter int unsigned FIFO_AW = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmem_ena,
  input  logic        dmem_W,
  input  logic        dmem_R,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_data_w,
  output logic [31:0] dmem_data_r,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned RAM_DEPTH  = 1 << RAM_AW;
  localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;
  localparam int unsigned CNT_W      = FIFO_AW + 1;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CYCLE  = 2'd2;

  // Access decode
  logic              wr_c;
  logic              rd_c;
  logic              sel_mmio_c;
  logic [1:0]        reg_idx_c;
  logic [RAM_AW-1:0] ram_idx_c;
  logic              ram_we_c;
  logic              push_c;
  logic              pop_c;
  logic              push_ok_c;
  logic              ovf_set_c;
  logic              ovf_clr_c;
  logic              cyc_wr_c;
  logic              empty_c;
  logic              full_c;
  logic              unused_addr;

  assign wr_c       = dmem_ena & dmem_W;
  assign rd_c       = dmem_ena & dmem_R;
  assign sel_mmio_c = dmem_addr[31];
  assign reg_idx_c  = dmem_addr[3:2];
  assign ram_idx_c  = dmem_addr[RAM_AW+1:2];
  assign ram_we_c   = wr_c & ~sel_mmio_c;
  assign push_c     = wr_c & sel_mmio_c & (reg_idx_c == REG_TXDATA);
  assign ovf_clr_c  = wr_c & sel_mmio_c & (reg_idx_c == REG_STATUS) & dmem_data_w[2];
  assign cyc_wr_c   = wr_c & sel_mmio_c & (reg_idx_c == REG_CYCLE);
  assign unused_addr = ^{dmem_addr[30:RAM_AW+2], dmem_addr[1:0]};

  // RAM storage: never reset; a write coinciding with reset is dropped
  logic [31:0] ram_mem [RAM_DEPTH];

  // RAM synchronous write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n && ram_we_c) begin
      ram_mem[ram_idx_c] <= dmem_data_w;
    end
  end

  // TX FIFO state
  logic [31:0]        fifo_mem_q [FIFO_DEPTH];
  logic [31:0]        fifo_mem_d [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  assign empty_c   = (count_q == '0);
  assign full_c    = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop_c     = tx_valid & tx_ready;
  // A push into a full FIFO only lands when the head leaves the same cycle
  assign push_ok_c = push_c & (~full_c | pop_c);
  assign ovf_set_c = push_c & full_c & ~pop_c;

  assign tx_valid = ~empty_c;
  assign tx_data  = empty_c ? 32'h0 : fifo_mem_q[rd_ptr_q];

  // FIFO next-state: pointers, occupancy, sticky overflow (set beats clear)
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    if (push_ok_c) begin
      fifo_mem_d[wr_ptr_q] = dmem_data_w;
      wr_ptr_d             = wr_ptr_q + FIFO_AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end
    case ({push_ok_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (ovf_set_c) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_c) begin
      ovf_d = 1'b0;
    end
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= 32'h0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  logic [31:0] cycle_rd_c;

`ifdef DMEM_RESP_CYCLE_CNT_EN
  logic [31:0] cycle_q, cycle_d;

  // Cycle counter next value: a CPU write loads without incrementing
  always_comb begin
    cycle_d = cycle_q + 32'd1;
    if (cyc_wr_c) begin
      cycle_d = dmem_data_w;
    end
  end

  // Cycle counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= 32'h0;
    end else begin
      cycle_q <= cycle_d;
    end
  end

  assign cycle_rd_c = cycle_q;
`else
  logic unused_cyc_wr;
  assign unused_cyc_wr = cyc_wr_c;
  assign cycle_rd_c    = 32'h0;
`endif

  // Combinational load data mux
  always_comb begin
    dmem_data_r = 32'h0;
    if (rd_c) begin
      if (sel_mmio_c) begin
        case (reg_idx_c)
          REG_STATUS: dmem_data_r = {16'h0, 8'(count_q), 5'h0, ovf_q, full_c, empty_c};
          REG_CYCLE:  dmem_data_r = cycle_rd_c;
          default:    dmem_data_r = 32'h0;
        endcase
      end else begin
        dmem_data_r = ram_mem[ram_idx_c];
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: queue-based reference model with per-cycle comparison,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_resp;

  localparam int unsigned RAM_AW  = 10;
  localparam int unsigned FIFO_AW = 2;
  localparam int unsigned DEPTH   = 1 << FIFO_AW;
`ifdef DMEM_RESP_CYCLE_CNT_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  localparam logic [31:0] A_TX  = 32'h8000_0000;
  localparam logic [31:0] A_ST  = 32'h8000_0004;
  localparam logic [31:0] A_CYC = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dmem_ena = 1'b0;
  logic        dmem_W = 1'b0;
  logic        dmem_R = 1'b0;
  logic [31:0] dmem_addr = 32'h0;
  logic [31:0] dmem_data_w = 32'h0;
  logic [31:0] dmem_data_r;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  always #5 clk = ~clk;

  dmem_resp #(.RAM_AW(RAM_AW), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .rst_n(rst_n), .dmem_ena(dmem_ena), .dmem_W(dmem_W),
    .dmem_R(dmem_R), .dmem_addr(dmem_addr), .dmem_data_w(dmem_data_w),
    .dmem_data_r(dmem_data_r), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mq[$];
  logic [31:0] mram[int];
  bit          movf;
  logic [31:0] mcyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    movf = 1'b0;
    mcyc = 32'h0;
  endtask

  function automatic logic [31:0] mstatus();
    int n = mq.size();
    return {16'h0, 8'(n), 5'h0, movf, 1'(n == DEPTH), 1'(n == 0)};
  endfunction

  // Advance the model by one clock edge using the inputs presented this cycle
  task automatic model_step();
    bit wr, mm, pop, was_full, set, clr;
    logic [1:0] rg;
    wr       = dmem_ena && dmem_W;
    mm       = dmem_addr[31];
    rg       = dmem_addr[3:2];
    pop      = (mq.size() > 0) && tx_ready;
    was_full = (mq.size() == DEPTH);
    set      = 1'b0;
    clr      = wr && mm && (rg == 2'd1) && dmem_data_w[2];
    if (pop) void'(mq.pop_front());
    if (wr && mm && rg == 2'd0) begin
      if (was_full && !pop) set = 1'b1;
      else mq.push_back(dmem_data_w);
    end
    if (set) movf = 1'b1;
    else if (clr) movf = 1'b0;
    if (CYC_EN) mcyc = (wr && mm && rg == 2'd2) ? dmem_data_w : mcyc + 32'd1;
    if (wr && !mm) mram[int'(dmem_addr[RAM_AW+1:2])] = dmem_data_w;
  endtask

  // Expected load data; returns 0 when the RAM word was never written
  function automatic bit exp_read(output logic [31:0] v);
    v = 32'h0;
    if (!(dmem_ena && dmem_R)) return 1'b1;
    if (dmem_addr[31]) begin
      case (dmem_addr[3:2])
        2'd1:    v = mstatus();
        2'd2:    v = CYC_EN ? mcyc : 32'h0;
        default: v = 32'h0;
      endcase
      return 1'b1;
    end
    if (!mram.exists(int'(dmem_addr[RAM_AW+1:2]))) return 1'b0;
    v = mram[int'(dmem_addr[RAM_AW+1:2])];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst_n) model_step();
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic [31:0] ev;
    if (rst_n) begin
      chk("tx_valid", 32'(tx_valid), 32'(mq.size() != 0));
      chk("tx_data", tx_data, (mq.size() != 0) ? mq[0] : 32'h0);
      if (exp_read(ev)) chk("dmem_data_r", dmem_data_r, ev);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dmem_ena = 1'b0;
    dmem_W   = 1'b0;
    dmem_R   = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    dmem_ena = 1'b1; dmem_W = 1'b1; dmem_R = 1'b0;
    dmem_addr = a; dmem_data_w = d;
    cyc();
    idle();
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    dmem_ena = 1'b1; dmem_W = 1'b0; dmem_R = 1'b1;
    dmem_addr = a;
    #1;
    chk(name, dmem_data_r, exp);
    cyc();
    idle();
  endtask

  task automatic tx_chk(input string name, input logic v, input logic [31:0] d);
    #1;
    chk({name, "_valid"}, 32'(tx_valid), 32'(v));
    chk({name, "_data"}, tx_data, d);
  endtask

  initial begin
    model_reset();
    idle();
    repeat (3) cyc();
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_tx_data", tx_data, 32'h0);
    chk("rst_data_r", dmem_data_r, 32'h0);
    rst_n = 1'b1;
    rd_chk("rst_cycle", A_CYC, 32'h0);
    rd_chk("rst_status", A_ST, 32'h0000_0001);

    // Preload a small RAM pool used by random traffic
    for (int i = 0; i < 16; i++) wr(32'(i) << 2, $urandom);

    // RAM round-trip and aliasing
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_alias", 32'h0000_1010, 32'hDEAD_BEEF);

    // FIFO stream
    tx_ready = 1'b0;
    wr(A_TX, 32'h11); wr(A_TX, 32'h22); wr(A_TX, 32'h33);
    rd_chk("stream_status", A_ST, 32'h0000_0300);
    tx_ready = 1'b1;
    tx_chk("stream0", 1'b1, 32'h11); cyc();
    tx_chk("stream1", 1'b1, 32'h22); cyc();
    tx_chk("stream2", 1'b1, 32'h33); cyc();
    tx_chk("stream_empty", 1'b0, 32'h0);
    tx_ready = 1'b0;
    rd_chk("stream_status_end", A_ST, 32'h0000_0001);

    // Overflow and clear
    for (int i = 1; i <= 5; i++) wr(A_TX, 32'hA0 + 32'(i));
    rd_chk("ovf_status", A_ST, 32'h0000_0406);
    wr(A_ST, 32'h4);
    rd_chk("ovf_clear", A_ST, 32'h0000_0402);
    tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tx_chk("ovf_drain", 1'b1, 32'hA0 + 32'(i));
      cyc();
    end
    tx_chk("ovf_drained", 1'b0, 32'h0);
    tx_ready = 1'b0;

    // Push into a full FIFO while the head pops
    for (int i = 1; i <= 4; i++) wr(A_TX, 32'hB0 + 32'(i));
    tx_ready = 1'b1;
    wr(A_TX, 32'h55);
    tx_ready = 1'b0;
    rd_chk("fullpop_status", A_ST, 32'h0000_0402);
    tx_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      tx_chk("fullpop_drain", 1'b1, 32'hB0 + 32'(i));
      cyc();
    end
    tx_chk("fullpop_last", 1'b1, 32'h55); cyc();
    tx_chk("fullpop_empty", 1'b0, 32'h0);
    tx_ready = 1'b0;

    // Cycle counter load and wrap
    wr(A_CYC, 32'hFFFF_FFFE);
    rd_chk("cyc0", A_CYC, CYC_EN ? 32'hFFFF_FFFE : 32'h0);
    rd_chk("cyc1", A_CYC, CYC_EN ? 32'hFFFF_FFFF : 32'h0);
    rd_chk("cyc2", A_CYC, 32'h0);

    // Asynchronous reset between edges
    for (int i = 1; i <= 5; i++) wr(A_TX, 32'hC0 + 32'(i));
    tx_ready = 1'b1;
    cyc(); cyc();
    tx_ready = 1'b0;
    rd_chk("pre_rst_status", A_ST, 32'h0000_0204);
    #1;
    rst_n = 1'b0;
    model_reset();
    dmem_ena = 1'b1; dmem_R = 1'b1; dmem_addr = A_ST;
    #1;
    chk("arst_tx_valid", 32'(tx_valid), 32'h0);
    chk("arst_status", dmem_data_r, 32'h0000_0001);
    rst_n = 1'b1;
    idle();
    rd_chk("arst_cycle", A_CYC, 32'h0);
    rd_chk("arst_ram", 32'h0000_0010, 32'hDEAD_BEEF);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      dmem_ena = ($urandom % 4) != 0;
      dmem_W   = 1'($urandom % 2);
      dmem_R   = 1'($urandom % 2);
      if ($urandom % 2 == 0) begin
        dmem_addr = {1'b1, 27'($urandom), 2'($urandom % 4), 2'($urandom)};
        if (dmem_addr[3:2] != 2'd0 && ($urandom % 2 == 0)) dmem_addr[3:2] = 2'd0;
      end else begin
        dmem_addr = {1'b0, 19'($urandom), 10'($urandom % 16), 2'($urandom)};
      end
      dmem_data_w = $urandom;
      tx_ready = (n < 1500) ? (($urandom % 8) == 0) : 1'($urandom % 2);
      cyc();
    end
    idle();
    tx_ready = 1'b1;
    repeat (8) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder for the single-cycle CPU core: it services the core's `dmem_*` initiator port with a word-addressed RAM and a small memory-mapped I/O window. The MMIO window holds a store-to-stream transmit FIFO (valid/ready output) and a free-running cycle counter. It sits beside the CPU in the top level, between the core's data port and the board-level debug/console sink.

## Interface
Parameters:
- `RAM_AW`, 10: RAM word-address width; the RAM holds 2^RAM_AW 32-bit words.
- `FIFO_AW`, 2: TX FIFO address width; the FIFO holds 2^FIFO_AW entries (power of two, ≥2).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dmem_ena`  in  1  access enable from the CPU.
- `dmem_W`  in  1  write strobe.
- `dmem_R`  in  1  read strobe.
- `dmem_addr`  in  32  byte address; bits [1:0] are ignored.
- `dmem_data_w`  in  32  store data.
- `dmem_data_r`  out  32  load data, combinational.
- `tx_data`  out  32  FIFO head word.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  sink accepts the head word.

## Operation
- Decode: `dmem_addr[31]`=0 selects RAM, with index `dmem_addr[RAM_AW+1:2]` (upper bits ignored, so the space wraps modulo depth). `dmem_addr[31]`=1 selects MMIO, with register index `dmem_addr[3:2]`; other address bits are ignored.
- Write = `dmem_ena & dmem_W`. Read = `dmem_ena & dmem_R`. If both are asserted, the write commits at the edge and the read returns the pre-edge value.
- `dmem_data_r` is 0 whenever read is low.
- RAM: asynchronous read, synchronous write. Contents are not cleared by reset.
- MMIO registers:
  - 0x0 TXDATA. A write pushes `dmem_data_w`. Reads return 0.
  - 0x4 STATUS. Read returns {16'h0, count[7:0], 5'h0, overflow, full, empty}. A write with `dmem_data_w[2]`=1 clears overflow.
  - 0x8 CYCLE. Read returns the counter. A write loads it.
  - 0xC: reads return 0; writes are ignored.
- FIFO:
  - Push: write to TXDATA.
  - Pop: `tx_valid & tx_ready`.
  - Push while full with no pop in the same cycle: data is dropped and overflow is set (sticky).
  - Push while full with a simultaneous pop: the push is accepted and count is unchanged.
  - Push and pop together on a non-full FIFO: count is unchanged.
  - Pointers wrap modulo 2^FIFO_AW. The count field is FIFO_AW+1 bits wide, zero-extended into count[7:0].
- Overflow: if a set and a clear occur on the same edge, set wins.
- The CPU cannot stall, so every access completes in the cycle it is presented.

## Timing
- Reset values:
  - `dmem_data_r` = 0 (read low), `tx_valid` = 0, `tx_data` = 0.
  - FIFO pointers and count = 0, overflow = 0, CYCLE = 0.
- Read latency: 0 cycles (combinational from address/strobes to `dmem_data_r`).
- Writes are visible to reads in the cycle after the edge.
- `tx_valid` rises in the cycle after the first push into an empty FIFO. `tx_data` equals the head entry whenever `tx_valid`=1 and is 0 when empty.
- `tx_data` must remain stable while `tx_valid`=1 and `tx_ready`=0.
- CYCLE increments by 1 every edge out of reset and wraps 0xFFFFFFFF→0. A CYCLE write at edge N sets the value to `dmem_data_w` with no increment at that edge; counting resumes at N+1.
- Reset asserted mid-operation clears the FIFO, overflow and CYCLE immediately (asynchronously). RAM contents are retained; any write on that edge is lost.

## Configuration
- `DMEM_RESP_CYCLE_CNT_EN` defined: the CYCLE register is implemented as above.
- Undefined: no counter flops are built; CYCLE reads return 0 and writes are ignored. All other behaviour is identical.

## Test plan
- RAM round-trip: write 0xDEADBEEF to 0x00000010, then read 0x00000010 → 0xDEADBEEF. With RAM_AW=10, read 0x00001010 → 0xDEADBEEF (aliasing/wrap).
- FIFO stream: `tx_ready`=0, push 0x11, 0x22, 0x33 to 0x80000000. STATUS → 0x00000300. Raise `tx_ready` → `tx_data` shows 0x11, 0x22, 0x33 on consecutive cycles, then `tx_valid`=0 and STATUS → 0x00000001.
- Overflow: FIFO_AW=2, `tx_ready`=0, push 5 words. STATUS → 0x00000406 and word 5 is never emitted. Write 0x4 to 0x80000004 → STATUS 0x00000402.
- Full with simultaneous pop: FIFO full and `tx_ready`=1 while pushing 0x55 → overflow stays 0, count stays 4, and 0x55 is emitted last.
- Cycle counter (macro defined): write 0xFFFFFFFE to 0x80000008 → reads 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 on the next three cycles. Macro undefined → reads 0.
- Async reset: with 2 entries queued and overflow set, pulse `rst_n` low between edges → `tx_valid`=0 and STATUS=0x00000001 immediately, with no clock edge required. Previously written RAM data is unchanged.
